// File: rtl/python_rx_decode.sv
`default_nettype none
// ============================================================================
//  Module      : python_rx_decode
//  Description : Receive-side sync decoder for the Python LVDS interface.
//                Locks on the training word, follows frame/line structure
//                from the sync channel and regenerates fval, lval and gated
//                pixel kernels. Two-stage pipeline: decode, then state/outputs.
//  Options     : PYTHON_RX_ERR_CNT_EN adds a saturating 16-bit error counter
//                output (ov_err_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module python_rx_decode #(
  parameter int unsigned           DATA_WIDTH  = 10,
  parameter int unsigned           CHANNEL_NUM = 4,
  parameter int unsigned           LOCK_CNT    = 8,
  parameter logic [DATA_WIDTH-1:0] TR_CODE     = 10'h3A6,
  parameter logic [DATA_WIDTH-1:0] FS_CODE     = 10'h2AA,
  parameter logic [DATA_WIDTH-1:0] FE_CODE     = 10'h32A,
  parameter logic [DATA_WIDTH-1:0] LS_CODE     = 10'h0AA,
  parameter logic [DATA_WIDTH-1:0] LE_CODE     = 10'h12A,
  parameter logic [DATA_WIDTH-1:0] IMG_CODE    = 10'h035,
  parameter logic [DATA_WIDTH-1:0] BL_CODE     = 10'h015,
  parameter logic [DATA_WIDTH-1:0] CRC_CODE    = 10'h059
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_data_valid,
  input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
  input  logic [DATA_WIDTH-1:0]             iv_ctrl_data,
  output logic                              o_locked,
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
`ifdef PYTHON_RX_ERR_CNT_EN
  output logic [15:0]                       ov_err_cnt,
`endif
  output logic                              o_err
);

  localparam int unsigned PIX_W     = DATA_WIDTH * CHANNEL_NUM;
  localparam logic [7:0]  LOCK_LAST = 8'(LOCK_CNT - 1);

  // One flag per sync code; unk marks a word that matches none of them.
  typedef struct packed {
    logic tr;
    logic fs;
    logic fe;
    logic ls;
    logic le;
    logic img;
    logic bl;
    logic crc;
    logic unk;
  } ctrl_flags_t;

  typedef enum logic [1:0] {
    ST_UNLOCK = 2'd0,
    ST_IDLE   = 2'd1,
    ST_FRAME  = 2'd2,
    ST_LINE   = 2'd3
  } state_t;

  ctrl_flags_t flags_d;
  ctrl_flags_t flags_q;
  logic        s1_valid_q;
  logic [PIX_W-1:0] s1_pix_q;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  lock_cnt_q;
  logic [7:0]  lock_cnt_d;

  logic        pix_word;
  logic        err_d;
  logic        fval_d;
  logic        locked_d;
  logic [PIX_W-1:0] pix_d;

  logic        locked_q;
  logic        fval_q;
  logic        lval_q;
  logic        err_q;
  logic [PIX_W-1:0] pix_q;

  // Decode the incoming sync word into one-hot code flags.
  always_comb begin
    flags_d     = '0;
    flags_d.tr  = (iv_ctrl_data == TR_CODE);
    flags_d.fs  = (iv_ctrl_data == FS_CODE);
    flags_d.fe  = (iv_ctrl_data == FE_CODE);
    flags_d.ls  = (iv_ctrl_data == LS_CODE);
    flags_d.le  = (iv_ctrl_data == LE_CODE);
    flags_d.img = (iv_ctrl_data == IMG_CODE);
    flags_d.bl  = (iv_ctrl_data == BL_CODE);
    flags_d.crc = (iv_ctrl_data == CRC_CODE);
    flags_d.unk = ~(flags_d.tr | flags_d.fs | flags_d.fe | flags_d.ls |
                    flags_d.le | flags_d.img | flags_d.bl | flags_d.crc);
  end

  // Stage 1: capture the word enable every cycle, payload only on valid words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_pix_q   <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= i_data_valid;
      if (i_data_valid) begin
        s1_pix_q <= iv_pix_data;
        flags_q  <= flags_d;
      end
    end
  end

  // State and training-run counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_UNLOCK;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Next-state logic and per-word output decisions for the stage-1 word.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    pix_word   = 1'b0;
    err_d      = 1'b0;
    fval_d     = fval_q;
    if (s1_valid_q) begin
      if ((state_q != ST_UNLOCK) && flags_q.unk) begin
        // Garbage on the sync channel means the word alignment is lost.
        err_d   = 1'b1;
        state_d = ST_UNLOCK;
      end else begin
        case (state_q)
          ST_UNLOCK: begin
            if (flags_q.tr) begin
              if (lock_cnt_q == LOCK_LAST) begin
                state_d    = ST_IDLE;
                lock_cnt_d = '0;
              end else begin
                lock_cnt_d = lock_cnt_q + 8'd1;
              end
            end else begin
              lock_cnt_d = '0;
            end
          end
          ST_IDLE: begin
            if (flags_q.fs) begin
              pix_word = 1'b1;
              state_d  = ST_LINE;
            end else if (flags_q.tr || flags_q.bl || flags_q.crc) begin
              state_d = ST_IDLE;
            end else begin
              err_d = 1'b1;
            end
          end
          ST_FRAME: begin
            if (flags_q.ls) begin
              pix_word = 1'b1;
              state_d  = ST_LINE;
            end else if (flags_q.tr || flags_q.bl || flags_q.crc) begin
              state_d = ST_FRAME;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
          ST_LINE: begin
            if (flags_q.img) begin
              pix_word = 1'b1;
            end else if (flags_q.le) begin
              pix_word = 1'b1;
              state_d  = ST_FRAME;
            end else if (flags_q.fe) begin
              pix_word = 1'b1;
              state_d  = ST_IDLE;
            end else if (flags_q.bl || flags_q.crc) begin
              state_d = ST_LINE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
          default: begin
            state_d    = ST_UNLOCK;
            lock_cnt_d = '0;
          end
        endcase
      end
      // The FE word itself still belongs to the frame through pix_word.
      fval_d = pix_word | (state_d == ST_FRAME) | (state_d == ST_LINE);
    end
    locked_d = (state_d != ST_UNLOCK);
    pix_d    = pix_word ? s1_pix_q : '0;
  end

  // Stage 2: registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_q <= 1'b0;
      fval_q   <= 1'b0;
      lval_q   <= 1'b0;
      err_q    <= 1'b0;
      pix_q    <= '0;
    end else begin
      locked_q <= locked_d;
      fval_q   <= fval_d;
      lval_q   <= pix_word;
      err_q    <= err_d;
      pix_q    <= pix_d;
    end
  end

  assign o_locked    = locked_q;
  assign o_fval      = fval_q;
  assign o_lval      = lval_q;
  assign o_err       = err_q;
  assign ov_pix_data = pix_q;

`ifdef PYTHON_RX_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Saturating count of protocol errors, aligned with the o_err pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign ov_err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/python_rx_decode.md
# python_rx_decode

Receive-side sync decoder for the Python LVDS sensor interface. It takes the parallel words recovered by the deserializer: 4 data channels plus the sync/control channel. It locks onto the training code, tracks frame and line structure from the embedded sync codes, and regenerates fval, lval and gated pixel data for the downstream image pipeline. It is the inverse of the sensor-model control-insert stage.

## Interface
- DATA_WIDTH, 10, bits per word per channel
- CHANNEL_NUM, 4, number of data channels
- LOCK_CNT, 8, consecutive training words required to lock (2..255)
- TR_CODE, 10'h3A6, training word
- FS_CODE, 10'h2AA, frame start (first kernel of first line)
- FE_CODE, 10'h32A, frame end (last kernel of last line)
- LS_CODE, 10'h0AA, line start
- LE_CODE, 10'h12A, line end
- IMG_CODE, 10'h035, valid image kernel
- BL_CODE, 10'h015, black kernel (dropped)
- CRC_CODE, 10'h059, CRC slot (ignored)
- clk  in  1  parallel word clock
- reset  in  1  asynchronous, active-high
- i_data_valid  in  1  word enable from deserializer; inputs ignored when low
- iv_pix_data  in  DATA_WIDTH*CHANNEL_NUM  data channels, ch0 in LSBs
- iv_ctrl_data  in  DATA_WIDTH  sync channel word
- o_locked  out  1  training lock achieved
- o_fval  out  1  frame valid
- o_lval  out  1  line valid, high only on valid pixel words
- ov_pix_data  out  DATA_WIDTH*CHANNEL_NUM  pixel kernel, zero when o_lval low
- o_err  out  1  one-cycle protocol-error pulse

## Operation
- Stage 1 registers inputs and decodes the ctrl word into one-hot flags. A word matching no code is "unknown".
- States:
  - UNLOCK: counts consecutive valid TR words; any other valid word clears the count. Count reaching LOCK_CNT -> IDLE with o_locked=1.
  - IDLE: FS -> LINE and the word is a pixel word; fval rises. TR/BL/CRC stay. LS/LE/FE/IMG -> o_err, stay.
  - FRAME (in frame, between lines): LS -> LINE, pixel word. TR/BL/CRC stay. FS/FE/LE/IMG -> o_err, go IDLE, fval drops.
  - LINE: IMG -> pixel word, stay. LE -> pixel word, then FRAME. FE -> pixel word, then IDLE; fval drops after this word. BL/CRC stay with no pixel word. FS/LS/TR -> o_err, go IDLE, drop fval and lval; the offending word is not output.
- An unknown word in any locked state -> o_err, go UNLOCK, o_locked=0, fval/lval drop.
- Pixel word: o_lval=1 and ov_pix_data=stage-1 data. Otherwise ov_pix_data=0.
- i_data_valid low: state, counters and o_fval hold; o_lval=0, o_err=0.

## Timing
- Reset values: o_locked=0, o_fval=0, o_lval=0, ov_pix_data=0, o_err=0; state UNLOCK; lock count 0.
- Latency is 2 clk from input word to its outputs (o_lval/ov_pix_data/o_err/o_fval).
- o_fval is high from the FS word through the FE word inclusive, as seen at the output.
- o_locked rises 2 clk after the LOCK_CNT-th TR word.
- Reset mid-line clears all outputs immediately (async); relock is required.
- FS and FE in the same line are legal (single-line frame ending FE).

## Configuration
- PYTHON_RX_ERR_CNT_EN defined: adds output ov_err_cnt [15:0], reset 0. It increments on every o_err pulse and saturates at 16'hFFFF.
- PYTHON_RX_ERR_CNT_EN undefined: the port and counter are absent; o_err behaviour is unchanged.

## Test plan
- 8 TR words then FS -> o_locked=1 at 2 clk after the 8th TR word. 7 TR + IMG + 8 TR -> lock only after the second run.
- Locked; FS,IMG,IMG,LE, TR,TR, LS,IMG,FE with data 0x123/0x0F0 per channel -> o_fval high for 9 output cycles. o_lval high on the 7 pixel words only; gaps show ov_pix_data=0; o_err never fires.
- Mid-line LS (FS,IMG,LS) -> o_err pulse on the LS word; o_fval/o_lval low 2 clk later; state IDLE. The next FS restarts the frame cleanly.
- Unknown ctrl 10'h3FF while locked -> o_err, o_locked=0. With PYTHON_RX_ERR_CNT_EN, ov_err_cnt=1.
- i_data_valid toggled 1/0 during a 4-kernel line -> exactly 4 o_lval pulses, o_fval steady high, data unchanged.
- Assert reset during LINE -> all outputs 0 within the same cycle; after release, 8 TR are needed before the next frame is output.
